// File: rtl/csr_int_unit_pkg.sv
// Shared constants for the machine-mode CSR / external interrupt unit.
// CSR addresses, trap cause value and trap FSM state encoding.
package csr_int_unit_pkg;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   localparam logic [31:0] MCAUSE_EXT = 32'h8000_000B;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PENDING   = 2'd1,
      SERVICING = 2'd2
   } state_t;

endpackage

// File: rtl/csr_int_unit_irq_sync.sv
// Multi-flop synchronizer for the async external IRQ line,
// followed by a rising-edge detector on the synchronized level.
module irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic irqAsync,
   output logic irqEdge
);

   logic [SYNC_STAGES-1:0] syncQ;
   logic                   prevQ;

   always_ff @(posedge CLK) begin
      if (RST) begin
         syncQ <= '0;
         prevQ <= 1'b0;
      end else begin
         syncQ <= {syncQ[SYNC_STAGES-2:0], irqAsync};
         prevQ <= syncQ[SYNC_STAGES-1];
      end
   end

   assign irqEdge = syncQ[SYNC_STAGES-1] & ~prevQ;

endmodule

// File: rtl/csr_int_unit.sv
// Machine-mode CSRs (mstatus/mie/mtvec/mepc/mcause) and the
// external-interrupt trap FSM feeding the control unit.
module csr_int_unit
   import csr_int_unit_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] RESET_VEC   = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IRQ_EXT,
   input  logic        INT_TAKEN,
   input  logic        CSR_WE,
   input  logic [11:0] CSR_ADDR,
   input  logic [31:0] CSR_WD,
   input  logic [31:0] PC,
   input  logic        MRET,
   output logic        INT,
   output logic [31:0] CSR_RD,
   output logic [31:0] MTVEC,
   output logic [31:0] MEPC
);

   state_t      state;
   logic        irqEdge;
   logic        pending;
   logic        mieBit;
   logic        mpieBit;
   logic        meieBit;
   logic        intQ;
   logic [31:0] mtvecQ;
   logic [31:0] mepcQ;
   logic [31:0] mcauseQ;
   logic [31:0] csrRdQ;
   logic [31:0] rdData;
   logic        take;
   logic        intEn;
   logic        wrMstatus;
   logic        wrMie;
   logic        wrMtvec;
   logic        wrMepc;

   irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) uSync (
      .CLK     (CLK),
      .RST     (RST),
      .irqAsync(IRQ_EXT),
      .irqEdge (irqEdge)
   );

   // Only the first INT_TAKEN cycle (still in PENDING) counts as the trap.
   assign take      = (state == PENDING) & INT_TAKEN;
   assign intEn     = mieBit & meieBit;
   assign wrMstatus = CSR_WE & (CSR_ADDR == ADDR_MSTATUS);
   assign wrMie     = CSR_WE & (CSR_ADDR == ADDR_MIE);
   assign wrMtvec   = CSR_WE & (CSR_ADDR == ADDR_MTVEC);
   assign wrMepc    = CSR_WE & (CSR_ADDR == ADDR_MEPC);

   always_comb begin
      rdData = 32'h0;
      case (CSR_ADDR)
         ADDR_MSTATUS: rdData = {24'h0, mpieBit, 3'b000, mieBit, 3'b000};
         ADDR_MIE:     rdData = {20'h0, meieBit, 11'h000};
         ADDR_MTVEC:   rdData = mtvecQ;
         ADDR_MEPC:    rdData = mepcQ;
         ADDR_MCAUSE:  rdData = mcauseQ;
         default:      rdData = 32'h0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         intQ    <= 1'b0;
         pending <= 1'b0;
         mieBit  <= 1'b0;
         mpieBit <= 1'b0;
         meieBit <= 1'b0;
         mtvecQ  <= RESET_VEC;
         mepcQ   <= 32'h0;
         mcauseQ <= 32'h0;
         csrRdQ  <= 32'h0;
      end else begin
         csrRdQ  <= rdData;
         pending <= irqEdge | (pending & ~take);

         if (wrMie)   meieBit <= CSR_WD[11];
         if (wrMtvec) mtvecQ  <= {CSR_WD[31:2], 2'b00};

         // Trap entry beats MRET, which beats a software write.
         if (take) begin
            mpieBit <= mieBit;
            mieBit  <= 1'b0;
            mcauseQ <= MCAUSE_EXT;
         end else if (MRET) begin
            mieBit  <= mpieBit;
            mpieBit <= 1'b1;
         end else if (wrMstatus) begin
            mieBit  <= CSR_WD[3];
            mpieBit <= CSR_WD[7];
         end

         if (take)
            mepcQ <= {PC[31:2], 2'b00};
         else if (wrMepc)
            mepcQ <= {CSR_WD[31:2], 2'b00};

         case (state)
            IDLE: begin
               if (pending & intEn) begin
                  state <= PENDING;
                  intQ  <= 1'b1;
               end
            end
            PENDING: begin
               if (INT_TAKEN) begin
                  state <= SERVICING;
                  intQ  <= 1'b0;
               end else if (!intEn) begin
                  state <= IDLE;
                  intQ  <= 1'b0;
               end
            end
            SERVICING: begin
               if (MRET) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               intQ  <= 1'b0;
            end
         endcase
      end
   end

   assign INT    = intQ;
   assign CSR_RD = csrRdQ;
   assign MTVEC  = mtvecQ;
   assign MEPC   = mepcQ;

endmodule

// File: tb/tb_csr_int_unit.sv
// Directed bench for csr_int_unit: CSR read/write table plus
// hand-written trap entry, nesting, masking and reset sequences.
module tb_csr_int_unit;

   localparam int          SYNC = 2;
   localparam logic [31:0] RVEC = 32'h0000_1000;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IRQ_EXT;
   logic        INT_TAKEN;
   logic        CSR_WE;
   logic [11:0] CSR_ADDR;
   logic [31:0] CSR_WD;
   logic [31:0] PC;
   logic        MRET;
   logic        INT;
   logic [31:0] CSR_RD;
   logic [31:0] MTVEC;
   logic [31:0] MEPC;

   int nTests = 0;
   int nFail  = 0;

   csr_int_unit #(
      .SYNC_STAGES(SYNC),
      .RESET_VEC  (RVEC)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .IRQ_EXT  (IRQ_EXT),
      .INT_TAKEN(INT_TAKEN),
      .CSR_WE   (CSR_WE),
      .CSR_ADDR (CSR_ADDR),
      .CSR_WD   (CSR_WD),
      .PC       (PC),
      .MRET     (MRET),
      .INT      (INT),
      .CSR_RD   (CSR_RD),
      .MTVEC    (MTVEC),
      .MEPC     (MEPC)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   task automatic csrWrite(input logic [11:0] a, input logic [31:0] d);
      CSR_WE   = 1'b1;
      CSR_ADDR = a;
      CSR_WD   = d;
      tick();
      CSR_WE   = 1'b0;
   endtask

   task automatic csrRead(input logic [11:0] a, output logic [31:0] v);
      CSR_WE   = 1'b0;
      CSR_ADDR = a;
      tick();
      v = CSR_RD;
   endtask

   task automatic pulseIrq();
      IRQ_EXT = 1'b1;
      tick();
      IRQ_EXT = 1'b0;
   endtask

   // Waits up to maxCyc ticks for INT; n = ticks spent (maxCyc+1 if never).
   task automatic waitInt(input int maxCyc, output int n);
      n = maxCyc + 1;
      for (int i = 1; i <= maxCyc; i++) begin
         tick();
         if (INT === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic quietInt(input string nm, input int cyc);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cyc; i++) begin
         tick();
         if (INT !== 1'b0) seen = 1'b1;
      end
      check(nm, {31'h0, seen}, 32'h0);
   endtask

   logic [31:0] rd;
   int          n;

   initial begin
      RST = 1'b1; IRQ_EXT = 1'b0; INT_TAKEN = 1'b0; CSR_WE = 1'b0;
      CSR_ADDR = 12'h0; CSR_WD = 32'h0; PC = 32'h0; MRET = 1'b0;

      vecs[0] = '{1'b1, 12'h305, 32'h0000_0103, 32'h0000_0100};
      vecs[1] = '{1'b1, 12'h304, 32'hFFFF_FFFF, 32'h0000_0800};
      vecs[2] = '{1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_0088};
      vecs[3] = '{1'b1, 12'h300, 32'h0000_0000, 32'h0000_0000};
      vecs[4] = '{1'b1, 12'h341, 32'h0000_0047, 32'h0000_0044};
      vecs[5] = '{1'b1, 12'h342, 32'h0000_1234, 32'h0000_0000};
      vecs[6] = '{1'b1, 12'h123, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[7] = '{1'b0, 12'h305, 32'h0000_0200, 32'h0000_0100};
      vecs[8] = '{1'b1, 12'h305, 32'h0000_0100, 32'h0000_0100};
      vecs[9] = '{1'b1, 12'h304, 32'h0000_0800, 32'h0000_0800};

      repeat (3) tick();
      RST = 1'b0;
      check("rst INT", {31'h0, INT}, 32'h0);
      check("rst MTVEC", MTVEC, RVEC);
      check("rst MEPC", MEPC, 32'h0);
      check("rst CSR_RD", CSR_RD, 32'h0);
      csrRead(12'h305, rd);
      check("rst read mtvec", rd, RVEC);

      foreach (vecs[i]) begin
         CSR_WE   = vecs[i].we;
         CSR_ADDR = vecs[i].addr;
         CSR_WD   = vecs[i].wd;
         tick();
         CSR_WE = 1'b0;
         tick();
         check($sformatf("vec%0d rd", i), CSR_RD, vecs[i].exp);
      end

      // Basic trap entry
      csrWrite(12'h300, 32'h8);
      pulseIrq();
      waitInt(SYNC + 1, n);
      check("int latency ok", {31'h0, (n + 1 <= SYNC + 2)}, 32'h1);
      PC = 32'h44; INT_TAKEN = 1'b1;
      tick();
      check("int drop on take", {31'h0, INT}, 32'h0);
      PC = 32'h100;
      tick();
      INT_TAKEN = 1'b0;
      check("mepc held", MEPC, 32'h44);
      check("mtvec out", MTVEC, 32'h100);
      csrRead(12'h342, rd);
      check("mcause", rd, 32'h8000_000B);
      csrRead(12'h300, rd);
      check("mstatus in trap", rd, 32'h80);

      // Second edge during SERVICING waits for MRET
      pulseIrq();
      quietInt("int quiet in svc", 6);
      MRET = 1'b1;
      tick();
      MRET = 1'b0;
      waitInt(2, n);
      check("int after mret", {31'h0, (n <= 2)}, 32'h1);
      csrRead(12'h300, rd);
      check("mstatus after mret", rd, 32'h88);
      PC = 32'h200; INT_TAKEN = 1'b1;
      tick();
      INT_TAKEN = 1'b0;
      check("mepc 2nd trap", MEPC, 32'h200);
      MRET = 1'b1;
      tick();
      MRET = 1'b0;

      // Masked interrupt is held until MIE set
      csrWrite(12'h300, 32'h0);
      pulseIrq();
      quietInt("int masked", 6);
      csrWrite(12'h300, 32'h8);
      tick();
      check("int unmasked", {31'h0, INT}, 32'h1);

      // Take coincident with mstatus write: trap wins
      PC = 32'h80; INT_TAKEN = 1'b1;
      CSR_WE = 1'b1; CSR_ADDR = 12'h300; CSR_WD = 32'h8;
      tick();
      INT_TAKEN = 1'b0; CSR_WE = 1'b0;
      csrRead(12'h300, rd);
      check("mstatus take wins", rd, 32'h80);
      check("mepc take", MEPC, 32'h80);

      // Reset while SERVICING, coincident with MRET
      RST = 1'b1; MRET = 1'b1;
      tick();
      RST = 1'b0; MRET = 1'b0;
      check("svc rst INT", {31'h0, INT}, 32'h0);
      check("svc rst MTVEC", MTVEC, RVEC);
      check("svc rst MEPC", MEPC, 32'h0);
      check("svc rst CSR_RD", CSR_RD, 32'h0);
      csrRead(12'h300, rd);
      check("svc rst mstatus", rd, 32'h0);
      csrRead(12'h342, rd);
      check("svc rst mcause", rd, 32'h0);

      // Clearing MIE in PENDING drops INT but keeps the request
      csrWrite(12'h304, 32'h800);
      csrWrite(12'h300, 32'h8);
      pulseIrq();
      waitInt(SYNC + 3, n);
      check("int rearm", {31'h0, (n <= SYNC + 3)}, 32'h1);
      csrWrite(12'h300, 32'h0);
      tick();
      check("int cancelled", {31'h0, INT}, 32'h0);
      csrWrite(12'h300, 32'h8);
      tick();
      check("pending retained", {31'h0, INT}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
